// File: rtl/wb_result_serializer.sv
// Writeback result serializer: queues 16-bit writeback results in a small FIFO
// and drains each word as two bytes (low then high) over a valid/ready byte bus.
module wb_result_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [PTR_W:0]   fifo_count,
  output logic             overflow
);

  localparam int unsigned BYTE_W   = 8;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND_LO = 2'd1;
  localparam logic [1:0] ST_SEND_HI = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic xfer_c;
  logic empty_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  assign xfer_c  = valid_q & out_ready;
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == FULL_CNT);

  // FSM next state: pops load the FIFO head into the holding register
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (xfer_c) begin
          state_d = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (xfer_c) begin
          if (!empty_c) begin
            pop_c   = 1'b1;
            hold_d  = mem_q[rd_ptr_q];
            state_d = ST_SEND_LO;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output bus is a pure function of next state and next holding word
  always_comb begin
    byte_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    case (state_d)
      ST_SEND_LO: begin
        byte_d  = hold_d[BYTE_W-1:0];
        valid_d = 1'b1;
      end
      ST_SEND_HI: begin
        byte_d  = hold_d[2*BYTE_W-1:BYTE_W];
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
      default: begin
        byte_d  = '0;
      end
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push when full
  always_comb begin
    push_c   = in_valid & (~full_c | pop_c);
    drop_c   = in_valid & full_c & ~pop_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop_c;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  // Storage array carries no reset; entries are only read after being written
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_byte   = byte_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
